// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared constants for the interrupt controller and CPU core.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    localparam int c_NUM_IRQ_DEFAULT = 6;
    localparam int c_REG_WIDTH       = 32;

    // MODE register layout: edge-select field low, polarity field high.
    localparam int c_MODE_EDGE_LSB = 0;
    localparam int c_MODE_POL_LSB  = 8;

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_PENDING = 2'd1,
        REG_MASK    = 2'd2,
        REG_MODE    = 2'd3
    } regAddr_e;

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_if
// Description : Register-access bus between the CPU core and irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic                   reg_en;
    logic                   reg_we;
    logic [1:0]             reg_addr;
    logic [c_REG_WIDTH-1:0] reg_wdata;
    logic [c_REG_WIDTH-1:0] reg_rdata;
    logic                   reg_ack;

    modport master (
        output reg_en, reg_we, reg_addr, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_en, reg_we, reg_addr, reg_wdata,
        output reg_rdata, reg_ack
    );

endinterface
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync
// Description : Multi-flop synchronizer for one asynchronous interrupt line.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic d,
    output logic      q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Interrupt controller: sync, polarity/edge handling, pending,
//               mask and register access feeding CP0 external interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ     = c_NUM_IRQ_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    input  wire logic [NUM_IRQ-1:0] irq_raw,
    irq_ctrl_if.slave               bus,
    output logic      [NUM_IRQ-1:0] int_out
);

    logic [NUM_IRQ-1:0]     w_sync;
    logic [NUM_IRQ-1:0]     w_adj;
    logic [NUM_IRQ-1:0]     w_newAdj;
    logic [NUM_IRQ-1:0]     w_newEdge;
    logic [NUM_IRQ-1:0]     w_newPol;
    logic [NUM_IRQ-1:0]     w_modeChg;
    logic [NUM_IRQ-1:0]     w_w1c;
    logic [NUM_IRQ-1:0]     w_rise;
    logic [NUM_IRQ-1:0]     w_pendingNext;
    logic [NUM_IRQ-1:0]     r_hist;
    logic [NUM_IRQ-1:0]     r_pending;
    logic [NUM_IRQ-1:0]     r_mask;
    logic [NUM_IRQ-1:0]     r_edgeMode;
    logic [NUM_IRQ-1:0]     r_pol;
    logic                   w_wrPending;
    logic                   w_wrMask;
    logic                   w_wrMode;
    logic [c_REG_WIDTH-1:0] w_rdata;
    logic                   w_unusedWdata;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        irq_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .resetn (resetn),
            .d      (irq_raw[i]),
            .q      (w_sync[i])
        );
    end

    assign w_wrPending = bus.reg_en & bus.reg_we & (bus.reg_addr == REG_PENDING);
    assign w_wrMask    = bus.reg_en & bus.reg_we & (bus.reg_addr == REG_MASK);
    assign w_wrMode    = bus.reg_en & bus.reg_we & (bus.reg_addr == REG_MODE);

    assign w_newEdge = w_wrMode ? bus.reg_wdata[c_MODE_EDGE_LSB +: NUM_IRQ] : r_edgeMode;
    assign w_newPol  = w_wrMode ? bus.reg_wdata[c_MODE_POL_LSB  +: NUM_IRQ] : r_pol;
    assign w_modeChg = (w_newEdge ^ r_edgeMode) | (w_newPol ^ r_pol);

    assign w_adj    = w_sync ^ r_pol;
    // History always captures the adjusted level under the polarity in force
    // next cycle, so a mode change never manufactures a rising edge.
    assign w_newAdj = w_sync ^ w_newPol;

    assign w_w1c  = w_wrPending ? bus.reg_wdata[NUM_IRQ-1:0] : '0;
    assign w_rise = w_adj & ~r_hist;

    // Edge lines: a new rise beats a simultaneous W1C. Level lines track adj.
    assign w_pendingNext = ~w_modeChg &
                           ((r_edgeMode & (w_rise | (r_pending & ~w_w1c))) |
                            (~r_edgeMode & w_adj));

    assign w_unusedWdata = ^bus.reg_wdata;

    always_comb begin
        w_rdata = '0;
        case (regAddr_e'(bus.reg_addr))
            REG_STATUS:  w_rdata[NUM_IRQ-1:0] = w_adj;
            REG_PENDING: w_rdata[NUM_IRQ-1:0] = r_pending;
            REG_MASK:    w_rdata[NUM_IRQ-1:0] = r_mask;
            REG_MODE: begin
                w_rdata[c_MODE_EDGE_LSB +: NUM_IRQ] = r_edgeMode;
                w_rdata[c_MODE_POL_LSB  +: NUM_IRQ] = r_pol;
            end
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hist        <= '0;
            r_pending     <= '0;
            r_mask        <= '0;
            r_edgeMode    <= '0;
            r_pol         <= '0;
            int_out       <= '0;
            bus.reg_rdata <= '0;
            bus.reg_ack   <= 1'b0;
        end else begin
            r_hist      <= w_newAdj;
            r_pending   <= w_pendingNext;
            r_edgeMode  <= w_newEdge;
            r_pol       <= w_newPol;
            int_out     <= r_pending & r_mask;
            bus.reg_ack <= bus.reg_en;
            if (w_wrMask) begin
                r_mask <= bus.reg_wdata[NUM_IRQ-1:0];
            end
            if (bus.reg_en && !bus.reg_we) begin
                bus.reg_rdata <= w_rdata;
            end
        end
    end

endmodule
`default_nettype wire
